// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RISC-V main controller:
// state enum, opcode constants, datapath mux encodings and the packed
// control word the FSM drives each cycle.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_JALR,
        S_BRANCH,
        S_LUI,
        S_FAULT
    } state_t;

    // Major opcodes recognised by DECODE.
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_ITYPE  = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    // Branch condition codes (funct3).
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ResultSrc encodings.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA encodings.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB encodings.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALUOp encodings.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ImmSrc encodings.
    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_SEXT = 2'b01;

    // Everything the controller drives in one cycle.
    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       fault;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // States that consume an immediate get the sign-extender enabled.
    function automatic logic [1:0] imm_src_for(state_t s);
        case (s)
            S_DECODE, S_MEMADR, S_EXECI, S_JAL, S_JALR, S_BRANCH, S_LUI:
                return IMM_SEXT;
            default:
                return IMM_NONE;
        endcase
    endfunction

    // Common exit rule for states waiting on mem_ready: completion wins
    // over an expired wait budget in the same cycle.
    function automatic state_t after_wait(state_t done_state, state_t cur,
                                          logic ready, logic expired);
        if (ready)
            return done_state;
        else if (expired)
            return S_FAULT;
        else
            return cur;
    endfunction

endpackage

// File: rtl/multicycle_control_branch.sv
// Branch condition evaluator: maps funct3 and the ALU compare flags to a
// take decision, flagging funct3 values this core does not implement.
module branch_eval
    import multicycle_control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       take,
    output logic       illegal
);

    // Decode the branch condition from funct3.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through the block leaves it unassigned, which would infer a latch.
        take    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  take = alu_zero;
            F3_BNE:  take = ~alu_zero;
            F3_BLT:  take = alu_lt;
            F3_BGE:  take = ~alu_lt;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main controller of a multicycle RISC-V datapath. A two-process FSM
// sequences fetch/decode/execute and drives the datapath enables, with a
// memory wait watchdog that parks the controller in an absorbing FAULT.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       mem_req,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       fault
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_next;
    ctrl_t      ctrl;
    logic [3:0] wait_cnt;
    logic       wait_expired;
    logic       waiting;
    logic       br_take;
    logic       br_illegal;

    // funct7b5 only matters to the ALU decoder further down the datapath.
    logic unused_funct7b5;
    assign unused_funct7b5 = funct7b5;

    branch_eval u_branch_eval (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .take     (br_take),
        .illegal  (br_illegal)
    );

    // The wait counter holds the number of cycles already spent waiting in
    // the current state; seeing MEM_TIMEOUT with no ready means give up.
    assign wait_expired = (wait_cnt == WAIT_LIMIT);
    assign waiting      = ctrl.mem_req & ~mem_ready;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    // Memory wait counter: cleared on any state change, counts stalled cycles.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= 4'd0;
        else if (state_next != state)
            wait_cnt <= 4'd0;
        else if (waiting)
            wait_cnt <= wait_cnt + 4'd1;
    end

    // Next-state and control-word decode for the current state.
    always_comb begin
        state_next   = state;
        ctrl         = CTRL_IDLE;
        ctrl.imm_src = imm_src_for(state);

        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                // Instruction and PC+4 are latched only when memory answers.
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end
                state_next = after_wait(S_DECODE, state, mem_ready, wait_expired);
            end

            S_DECODE: begin
                // Precompute OldPC + ImmExt as a branch/jump target.
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_FAULT;
                endcase
            end

            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_next     = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end

            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                state_next   = after_wait(S_MEMWB, state, mem_ready, wait_expired);
            end

            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_DATA;
                state_next      = S_FETCH;
            end

            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
                state_next     = after_wait(S_FETCH, state, mem_ready, wait_expired);
            end

            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_next     = S_ALUWB;
            end

            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_next     = S_ALUWB;
            end

            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                state_next      = S_FETCH;
            end

            S_JAL: begin
                // PC takes the target computed in DECODE; ALU forms the link.
                ctrl.pc_write   = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                state_next      = S_ALUWB;
            end

            S_JALR: begin
                // Register-relative target goes straight from the ALU to PC.
                ctrl.pc_write   = 1'b1;
                ctrl.result_src = RES_ALURESULT;
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
                state_next      = S_ALUWB;
            end

            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = br_take & ~br_illegal;
                state_next      = br_illegal ? S_FAULT : S_FETCH;
            end

            S_LUI: begin
                // Datapath forces RD1 to x0, so the sum is the immediate.
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_next     = S_ALUWB;
            end

            S_FAULT: begin
                ctrl.fault = 1'b1;
                state_next = S_FAULT;
            end

            default: begin
                state_next = S_FAULT;
            end
        endcase

        // A reset cycle aborts any transfer: nothing is enabled or requested.
        if (rst)
            ctrl = CTRL_IDLE;
    end

    assign mem_req   = ctrl.mem_req;
    assign PCWrite   = ctrl.pc_write;
    assign AdrSrc    = ctrl.adr_src;
    assign MemWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign RegWrite  = ctrl.reg_write;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign ImmSrc    = ctrl.imm_src;
    assign fault     = ctrl.fault;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model that
// is compared with the DUT outputs on every falling clock edge.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       alu_zero;
    logic       alu_lt;
    logic       mem_req;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       fault;

    multicycle_control #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .alu_zero  (alu_zero),
        .alu_lt    (alu_lt),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    //  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, fault}
    logic [16:0] outs;
    assign outs = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, fault};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_state(input string name, input state_t expected);
        check(name, 32'(dut.state), 32'(expected));
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_FETCH, M_DECODE, M_MEMADR, M_MEMREAD, M_MEMWB, M_MEMWRITE,
                  M_EXECR, M_EXECI, M_ALUWB, M_JAL, M_JALR, M_BRANCH, M_LUI,
                  M_FAULT} mstate_e;

    mstate_e m_st = M_FETCH;
    int      m_waited = 0;
    bit      m_valid = 1'b0;

    function automatic logic m_legal_branch(logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // Even funct3 tests the flag, odd funct3 tests its complement;
    // bit 2 picks less-than over equality.
    function automatic logic m_take(logic [2:0] f3, logic z, logic lt);
        logic flag;
        flag = f3[2] ? lt : z;
        return flag ^ f3[0];
    endfunction

    function automatic mstate_e m_wait(mstate_e done_s, mstate_e s, logic rdy, int waited);
        if (rdy) return done_s;
        if (waited >= TIMEOUT) return M_FAULT;
        return s;
    endfunction

    function automatic mstate_e m_next(mstate_e s, logic [6:0] o, logic [2:0] f3,
                                       logic rdy, int waited);
        case (s)
            M_FETCH:    return m_wait(M_DECODE, s, rdy, waited);
            M_DECODE: begin
                case (o)
                    7'd3, 7'd35: return M_MEMADR;
                    7'd51:       return M_EXECR;
                    7'd19:       return M_EXECI;
                    7'd111:      return M_JAL;
                    7'd103:      return M_JALR;
                    7'd99:       return M_BRANCH;
                    7'd55:       return M_LUI;
                    default:     return M_FAULT;
                endcase
            end
            M_MEMADR:   return (o == 7'd3) ? M_MEMREAD : M_MEMWRITE;
            M_MEMREAD:  return m_wait(M_MEMWB, s, rdy, waited);
            M_MEMWRITE: return m_wait(M_FETCH, s, rdy, waited);
            M_BRANCH:   return m_legal_branch(f3) ? M_FETCH : M_FAULT;
            M_EXECR, M_EXECI, M_JAL, M_JALR, M_LUI: return M_ALUWB;
            M_FAULT:    return M_FAULT;
            default:    return M_FETCH;
        endcase
    endfunction

    function automatic logic [16:0] model_out(mstate_e s, logic r, logic rdy,
                                              logic [2:0] f3, logic z, logic lt);
        logic req, pcw, adr, mw, irw, rw, flt;
        logic [1:0] res, sa, sb, aop, imm;
        {req, pcw, adr, mw, irw, rw, flt} = '0;
        {res, sa, sb, aop} = '0;
        imm = (s inside {M_DECODE, M_MEMADR, M_EXECI, M_JAL, M_JALR, M_BRANCH, M_LUI})
              ? 2'b01 : 2'b00;
        case (s)
            M_FETCH:    begin req = 1; sb = 2; res = 2; irw = rdy; pcw = rdy; end
            M_DECODE:   begin sa = 1; sb = 1; end
            M_MEMADR:   begin sa = 2; sb = 1; end
            M_MEMREAD:  begin req = 1; adr = 1; end
            M_MEMWB:    begin rw = 1; res = 1; end
            M_MEMWRITE: begin req = 1; mw = 1; adr = 1; end
            M_EXECR:    begin sa = 2; aop = 2; end
            M_EXECI:    begin sa = 2; sb = 1; aop = 2; end
            M_ALUWB:    begin rw = 1; end
            M_JAL:      begin pcw = 1; sa = 1; sb = 2; end
            M_JALR:     begin pcw = 1; sa = 2; sb = 1; res = 2; end
            M_BRANCH:   begin sa = 2; aop = 1; pcw = m_legal_branch(f3) & m_take(f3, z, lt); end
            M_LUI:      begin sa = 2; sb = 1; end
            M_FAULT:    begin flt = 1; end
            default:    begin end
        endcase
        if (r) return 17'd0;
        return {req, pcw, adr, mw, irw, rw, res, sa, sb, aop, imm, flt};
    endfunction

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        mstate_e nxt;
        if (rst) begin
            m_st     <= M_FETCH;
            m_waited <= 0;
            m_valid  <= 1'b1;
        end else if (m_valid) begin
            nxt = m_next(m_st, op, funct3, mem_ready, m_waited);
            if (nxt != m_st)
                m_waited <= 0;
            else if ((m_st inside {M_FETCH, M_MEMREAD, M_MEMWRITE}) && !mem_ready)
                m_waited <= m_waited + 1;
            m_st <= nxt;
        end
    end

    // Compare every control output against the model mid-cycle.
    always @(negedge clk) begin
        if (m_valid)
            check($sformatf("ctrl_%s", m_st.name()), 32'(outs),
                  32'(model_out(m_st, rst, mem_ready, funct3, alu_zero, alu_lt)));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        step();
        step();
        #1;
        check("rst_outs_zero", 32'(outs), 32'd0);
        rst = 1'b0;
        #1;
        check_state("rst_release_fetch", S_FETCH);
        check("rst_release_mem_req", 32'(mem_req), 32'd1);
        check("rst_release_fault", 32'(fault), 32'd0);
    endtask

    // Called while in FETCH; completes the fetch and lands in DECODE.
    task automatic do_fetch(input logic [6:0] o, input logic [2:0] f3);
        op = o;
        funct3 = f3;
        mem_ready = 1'b1;
        #1;
        check("fetch_ir_pc_write", 32'({IRWrite, PCWrite}), 32'd3);
        step();
        mem_ready = 1'b0;
        #1;
        check_state("fetch_to_decode", S_DECODE);
    endtask

    initial begin
        rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0;
        alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;

        // addi
        do_reset();
        do_fetch(7'd19, 3'd0);
        step(); #1;
        check_state("addi_execi", S_EXECI);
        check("addi_execi_imm", 32'(ImmSrc), 32'd1);
        check("addi_execi_regwrite", 32'(RegWrite), 32'd0);
        step(); #1;
        check_state("addi_aluwb", S_ALUWB);
        check("addi_aluwb_regwrite", 32'(RegWrite), 32'd1);
        step(); #1;
        check_state("addi_back_fetch", S_FETCH);

        // lw with three stalled cycles in MEMREAD
        do_fetch(7'd3, 3'b010);
        step(); #1;
        check_state("lw_memadr", S_MEMADR);
        for (int i = 0; i < 4; i++) begin
            step();
            mem_ready = (i == 3);
            #1;
            check_state($sformatf("lw_memread_%0d", i), S_MEMREAD);
        end
        step();
        mem_ready = 1'b0;
        #1;
        check_state("lw_memwb", S_MEMWB);
        check("lw_memwb_ctrl", 32'({ResultSrc, RegWrite}), 32'b011);
        step(); #1;
        check_state("lw_back_fetch", S_FETCH);

        // bne taken and not taken
        for (int z = 0; z < 2; z++) begin
            do_fetch(7'd99, 3'b001);
            alu_zero = z[0];
            step(); #1;
            check_state("bne_branch", S_BRANCH);
            check($sformatf("bne_pcwrite_z%0d", z), 32'(PCWrite), (z == 0) ? 32'd1 : 32'd0);
            step(); #1;
            check_state("bne_back_fetch", S_FETCH);
        end

        // sw with memory never answering: 15 wait cycles, then FAULT
        do_fetch(7'd35, 3'b010);
        step();
        for (int i = 0; i <= TIMEOUT; i++) begin
            step(); #1;
            check_state($sformatf("sw_wait_%0d", i), S_MEMWRITE);
        end
        step(); #1;
        check_state("sw_timeout_fault", S_FAULT);
        check("sw_timeout_outs", 32'(outs), 32'd1);

        // sw with ready arriving exactly at the limit
        do_reset();
        do_fetch(7'd35, 3'b010);
        step();
        for (int i = 0; i <= TIMEOUT; i++) begin
            step();
            mem_ready = (i == TIMEOUT);
            #1;
            check_state($sformatf("sw_late_%0d", i), S_MEMWRITE);
        end
        step();
        mem_ready = 1'b0;
        #1;
        check_state("sw_late_fetch", S_FETCH);
        check("sw_late_no_fault", 32'(fault), 32'd0);

        // illegal opcode
        do_fetch(7'h7F, 3'd0);
        step(); #1;
        check_state("illegal_fault", S_FAULT);
        check("illegal_outs", 32'(outs), 32'd1);
        mem_ready = 1'b1;
        repeat (3) step();
        #1;
        check("illegal_absorbing", 32'(outs), 32'd1);
        do_reset();

        // reset in the middle of a store
        do_fetch(7'd35, 3'b010);
        step(); step(); #1;
        check("midwrite_memwrite_on", 32'(MemWrite), 32'd1);
        rst = 1'b1;
        #1;
        check("midwrite_rst_memwrite", 32'(MemWrite), 32'd0);
        check("midwrite_rst_mem_req", 32'(mem_req), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_state("midwrite_fetch", S_FETCH);
        check("midwrite_fetch_req", 32'(mem_req), 32'd1);

        // randomized traffic
        begin
            logic [6:0] legal_ops [8];
            int stall_left;
            legal_ops = '{7'd3, 7'd19, 7'd35, 7'd51, 7'd55, 7'd99, 7'd103, 7'd111};
            stall_left = 0;
            for (int n = 0; n < 4000; n++) begin
                step();
                if (m_st == M_FAULT)
                    rst = ($urandom_range(0, 3) == 0);
                else
                    rst = ($urandom_range(0, 299) == 0);
                if (stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 99) == 0)
                        stall_left = $urandom_range(10, 20);
                end
                if (m_st == M_FETCH) begin
                    int r;
                    r = $urandom_range(0, 17);
                    op = (r < 16) ? legal_ops[r % 8] : 7'($urandom_range(0, 127));
                    funct3 = 3'($urandom_range(0, 7));
                    funct7b5 = 1'($urandom_range(0, 1));
                end
                alu_zero = 1'($urandom_range(0, 1));
                alu_lt = 1'($urandom_range(0, 1));
            end
        end

        rst = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
